// File: rtl/cpu_writeback_scheduler_pkg.sv
// Shared widths and source ids for the writeback scheduler and its scoreboard.
package cpu_writeback_scheduler_pkg;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN         = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        WB_SRC_FAST = 1'b0,
        WB_SRC_SLOW = 1'b1
    } wb_src_e;
endpackage

// File: rtl/cpu_writeback_scheduler_scoreboard.sv
// Pending long-latency destination tracking, RAW/WAW hazard detection and sticky
// error flag for a src1 write that arrives for a register that was never marked.
module cpu_scoreboard
    import cpu_writeback_scheduler_pkg::*;
#(
    parameter bit HARDWIRE_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  iss_rd_we,
    input  logic                  iss_long,
    input  logic                  wb1_xfer,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    output logic                  iss_stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  sb_err
);
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                sb_err_q, sb_err_d;
    logic                hazard;
    logic                iss_accept;

    always_comb begin
        // Registered busy only: a src1 write committing this cycle still stalls.
        hazard     = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_rd_we & busy_q[iss_rd]);
        iss_stall  = !rst_n | hazard;
        iss_accept = iss_valid & !iss_stall;

        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (wb1_xfer) begin
            busy_d[wb1_rd] = 1'b0;
            if (!busy_q[wb1_rd] && !(HARDWIRE_ZERO && wb1_rd == '0)) begin
                sb_err_d = 1'b1;
            end
        end
        if (iss_accept && iss_long && iss_rd_we && (iss_rd != '0 || !HARDWIRE_ZERO)) begin
            busy_d[iss_rd] = 1'b1;
        end
        if (HARDWIRE_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign busy   = busy_q;
    assign sb_err = sb_err_q;
endmodule

// File: rtl/cpu_writeback_scheduler.sv
// Arbitrates the single register-file write port between the fast ALU (src0) and
// the long-latency unit (src1), with an anti-starvation override for src1.
module cpu_writeback_scheduler
    import cpu_writeback_scheduler_pkg::*;
#(
    parameter bit HARDWIRE_ZERO = 1'b1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  iss_rd_we,
    input  logic                  iss_long,
    output logic                  iss_stall,
    input  logic                  wb0_valid,
    input  logic [REG_ADDR_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]       wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]       wb1_data,
    output logic                  wb1_ready,
    output logic [REG_ADDR_W-1:0] rf_a3,
    output logic [XLEN-1:0]       rf_wd3,
    output logic                  rf_we3,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  sb_err
);
    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    force_slow;
    wb_src_e                 grant_src;

    always_comb begin
        force_slow = (starve_q == STARVE_MAX) && wb1_valid;
        grant_src  = WB_SRC_FAST;
        if (wb1_valid && (force_slow || !wb0_valid)) begin
            grant_src = WB_SRC_SLOW;
        end

        // Readies are masked during reset so nothing can handshake while rst_n is low.
        wb0_ready = rst_n && wb0_valid && (grant_src == WB_SRC_FAST);
        wb1_ready = rst_n && wb1_valid && (grant_src == WB_SRC_SLOW);

        rf_a3  = (grant_src == WB_SRC_SLOW) ? wb1_rd   : wb0_rd;
        rf_wd3 = (grant_src == WB_SRC_SLOW) ? wb1_data : wb0_data;
        rf_we3 = (wb0_ready || wb1_ready) && !(HARDWIRE_ZERO && rf_a3 == '0);

        starve_d = starve_q;
        if (wb1_ready) begin
            starve_d = '0;
        end else if (wb1_valid && starve_q < STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    cpu_scoreboard #(
        .HARDWIRE_ZERO (HARDWIRE_ZERO)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_rd_we (iss_rd_we),
        .iss_long  (iss_long),
        .wb1_xfer  (wb1_valid && wb1_ready),
        .wb1_rd    (wb1_rd),
        .iss_stall (iss_stall),
        .busy      (busy),
        .sb_err    (sb_err)
    );
endmodule

// File: tb/tb_cpu_writeback_scheduler.sv
// Directed bench for cpu_writeback_scheduler: arbitration vector table plus
// hand sequences for reset, starvation, RAW hazard, x0 and scoreboard error.
module tb_cpu_writeback_scheduler;
  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rd_we, iss_long, iss_stall;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic        rf_we3;
  logic [31:0] busy;
  logic        sb_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic        w0v;
    logic [4:0]  w0rd;
    logic [31:0] w0d;
    logic        w1v;
    logic [4:0]  w1rd;
    logic [31:0] w1d;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[9];

  cpu_writeback_scheduler #(
    .HARDWIRE_ZERO (1'b1),
    .STARVE_LIMIT  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_rd_we (iss_rd_we),
    .iss_long  (iss_long),
    .iss_stall (iss_stall),
    .wb0_valid (wb0_valid),
    .wb0_rd    (wb0_rd),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_rd    (wb1_rd),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .rf_we3    (rf_we3),
    .busy      (busy),
    .sb_err    (sb_err)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    iss_rd_we = 1'b0; iss_long = 1'b0;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rd_we, input logic lng);
    iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
    iss_rd_we = rd_we; iss_long = lng;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("in_reset_stall", {31'd0, iss_stall}, 32'd1);
    chk("in_reset_busy", busy, 32'd0);
    chk("in_reset_sb_err", {31'd0, sb_err}, 32'd0);
    chk("in_reset_we3", {31'd0, rf_we3}, 32'd0);
    chk("in_reset_ready", {30'd0, wb1_ready, wb0_ready}, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [36:0] exp_w;
    // {w0v,w0rd,w0d, w1v,w1rd,w1d, r0,r1,we,a3,wd}
    vecs[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1] = '{1'b1, 5'd1,  32'h1111_1111, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_1111};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0077};
    vecs[3] = '{1'b1, 5'd3,  32'hAAAA_0003, 1'b1, 5'd5, 32'h5555_0005, 1'b1, 1'b0, 1'b1, 5'd3,  32'hAAAA_0003};
    vecs[4] = '{1'b1, 5'd9,  32'h9999_0009, 1'b1, 5'd5, 32'h5555_0005, 1'b1, 1'b0, 1'b1, 5'd9,  32'h9999_0009};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5, 32'h5555_0005, 1'b0, 1'b1, 1'b1, 5'd5,  32'h5555_0005};
    vecs[6] = '{1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[8] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("por_busy", busy, 32'd0);
    chk("por_stall", {31'd0, iss_stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("por_release_stall", {31'd0, iss_stall}, 32'd0);
    chk("por_sb_err", {31'd0, sb_err}, 32'd0);

    // arbitration table
    for (int i = 0; i < 9; i++) begin
      wb0_valid = vecs[i].w0v; wb0_rd = vecs[i].w0rd; wb0_data = vecs[i].w0d;
      wb1_valid = vecs[i].w1v; wb1_rd = vecs[i].w1rd; wb1_data = vecs[i].w1d;
      if (vecs[i].e_we) exp_q.push_back({vecs[i].e_a3, vecs[i].e_wd});
      #1;
      chk($sformatf("vec%0d_wb0_ready", i), {31'd0, wb0_ready}, {31'd0, vecs[i].e_r0});
      chk($sformatf("vec%0d_wb1_ready", i), {31'd0, wb1_ready}, {31'd0, vecs[i].e_r1});
      chk($sformatf("vec%0d_rf_we3", i), {31'd0, rf_we3}, {31'd0, vecs[i].e_we});
      if (rf_we3) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("vec%0d_unexpected_write", i), {27'd0, rf_a3}, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          chk($sformatf("vec%0d_rf_a3", i), {27'd0, rf_a3}, {27'd0, exp_w[36:32]});
          chk($sformatf("vec%0d_rf_wd3", i), rf_wd3, exp_w[31:0]);
        end
      end
      next_cycle();
    end
    chk("write_queue_empty", exp_q.size(), 32'd0);
    idle_inputs();

    // reset mid-run with busy[8] set
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    next_cycle();
    idle_inputs();
    chk("pre_reset_busy", busy, 32'h0000_0100);
    #2;
    wb0_valid = 1'b1; wb0_rd = 5'd4; wb0_data = 32'h4444_4444;
    do_reset();
    chk("post_reset_stall", {31'd0, iss_stall}, 32'd0);

    // RAW hazard against a pending long write
    issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
    #1;
    chk("raw_issue_stall", {31'd0, iss_stall}, 32'd0);
    next_cycle();
    idle_inputs();
    chk("raw_busy8", busy, 32'h0000_0100);
    issue(5'd8, 5'd0, 5'd2, 1'b1, 1'b0);
    #1;
    chk("raw_stall_rs1", {31'd0, iss_stall}, 32'd1);
    next_cycle();
    wb1_valid = 1'b1; wb1_rd = 5'd8; wb1_data = 32'h8888_0008;
    #1;
    chk("raw_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("raw_stall_during_wb", {31'd0, iss_stall}, 32'd1);
    next_cycle();
    wb1_valid = 1'b0;
    #1;
    chk("raw_stall_after_wb", {31'd0, iss_stall}, 32'd0);
    chk("raw_busy_clear", busy, 32'd0);
    chk("raw_no_sb_err", {31'd0, sb_err}, 32'd0);
    next_cycle();
    idle_inputs();

    // WAW hazard: rd busy, sources free
    issue(5'd0, 5'd0, 5'd20, 1'b1, 1'b1);
    next_cycle();
    issue(5'd1, 5'd2, 5'd20, 1'b1, 1'b0);
    #1;
    chk("waw_stall", {31'd0, iss_stall}, 32'd1);
    iss_rd_we = 1'b0;
    #1;
    chk("waw_no_we_no_stall", {31'd0, iss_stall}, 32'd0);
    idle_inputs();
    wb1_valid = 1'b1; wb1_rd = 5'd20; wb1_data = 32'h2020_2020;
    next_cycle();
    idle_inputs();
    chk("waw_clear", busy, 32'd0);

    // x0 handling
    wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'hDEAD_BEEF;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    #1;
    chk("x0_wb0_ready", {31'd0, wb0_ready}, 32'd1);
    chk("x0_we3", {31'd0, rf_we3}, 32'd0);
    chk("x0_issue_stall", {31'd0, iss_stall}, 32'd0);
    next_cycle();
    idle_inputs();
    chk("x0_busy", busy, 32'd0);

    // starvation: src1 wins on exactly the 5th contended cycle
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'hAAAA_0003;
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h5555_0005;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_c%0d_wb1_ready", c), {31'd0, wb1_ready}, {31'd0, (c == 4)});
      chk($sformatf("starve_c%0d_wb0_ready", c), {31'd0, wb0_ready}, {31'd0, (c != 4)});
      chk($sformatf("starve_c%0d_a3", c), {27'd0, rf_a3}, (c == 4) ? 32'd0 : 32'd3);
      next_cycle();
    end
    idle_inputs();
    chk("starve_no_sb_err", {31'd0, sb_err}, 32'd0);

    // scoreboard error is sticky until reset
    wb1_valid = 1'b1; wb1_rd = 5'd12; wb1_data = 32'hC0C0_000C;
    #1;
    chk("err_wb1_ready", {31'd0, wb1_ready}, 32'd1);
    chk("err_before", {31'd0, sb_err}, 32'd0);
    next_cycle();
    idle_inputs();
    chk("err_set", {31'd0, sb_err}, 32'd1);
    next_cycle();
    next_cycle();
    chk("err_sticky", {31'd0, sb_err}, 32'd1);
    #2;
    do_reset();
    chk("err_cleared_by_reset", {31'd0, sb_err}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_writeback_scheduler.md
Name: cpu_writeback_scheduler

Overview:
- Shares the register file's single write port (a3/wd3/we3) between two writeback sources.
  - src0: the fast ALU pipeline.
  - src1: the long-latency unit (load/mul-div).
- Holds a scoreboard of registers with pending long-latency writes and stalls issue on RAW/WAW hazards against them.
- Sits between the issue stage, the execution units and the register file write port.

Parameters:
- HARDWIRE_ZERO, 1: x0 is never written and never marked busy; matches the register file setting.
- STARVE_LIMIT, 4: consecutive cycles src1 may lose arbitration before it is forced to win (range 1..15).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  issue stage presents an instruction
- iss_rs1  in  5  source register 1
- iss_rs2  in  5  source register 2
- iss_rd  in  5  destination register
- iss_rd_we  in  1  instruction writes iss_rd
- iss_long  in  1  destination is produced by src1
- iss_stall  out  1  hazard; issue not accepted this cycle
- wb0_valid  in  1  src0 write request
- wb0_rd  in  5  src0 destination
- wb0_data  in  32  src0 data
- wb0_ready  out  1  src0 granted this cycle
- wb1_valid  in  1  src1 write request
- wb1_rd  in  5  src1 destination
- wb1_data  in  32  src1 data
- wb1_ready  out  1  src1 granted this cycle
- rf_a3  out  5  register file write address
- rf_wd3  out  32  register file write data
- rf_we3  out  1  register file write enable
- busy  out  32  scoreboard bits (bit 0 always 0 when HARDWIRE_ZERO)
- sb_err  out  1  sticky: src1 wrote a register that was not busy

Behaviour:
- Reset (rst_n low, asynchronous): busy=0, starve counter=0, sb_err=0.
  - While rst_n is low: wb0_ready=wb1_ready=0, rf_we3=0, iss_stall=1.
- Arbitration is combinational, with no added latency from request to rf_we3 in the same cycle.
  - Default: src0 has priority.
  - If the starve counter equals STARVE_LIMIT and wb1_valid is high, src1 has priority.
  - Exactly one ready is high when any valid is high; both are low when neither is valid.
- Write port drive:
  - rf_a3/rf_wd3 come from the granted source.
  - rf_we3 = granted valid AND NOT (HARDWIRE_ZERO and granted rd==0).
  - A write to x0 still completes its handshake.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle wb1_valid=1 and wb1_ready=0.
  - Clears on a src1 grant.
  - Holds when wb1_valid=0.
- Handshake: a source must hold rd/data stable while valid and not ready. Transfer occurs on posedge when valid and ready are both high.
- Issue acceptance: accepted when iss_valid and !iss_stall.
  - iss_stall = busy[rs1] | busy[rs2] | (iss_rd_we & busy[rd]), using the registered busy only.
  - No same-cycle bypass of a committing src1 write: the register file returns the old value, so the stall holds one more cycle.
- Scoreboard set: on an accepted issue with iss_long & iss_rd_we & (rd!=0 or !HARDWIRE_ZERO), busy[rd]<=1 at posedge.
- Scoreboard clear: on a src1 transfer, busy[wb1_rd]<=0.
  - If busy[wb1_rd] was 0 (and the write is not to x0 with HARDWIRE_ZERO), sb_err<=1. It is cleared only by reset.
- Simultaneous set and clear of different registers in one cycle: both take effect.
  - Same register cannot occur, since issue to a busy rd stalls (WAW).
- src0 transfers never touch the scoreboard.
- Reset mid-operation: all busy bits drop immediately; in-flight requests are discarded by the sources' own reset.

Decomposition:
- Shared include/package constants:
  - REG_ADDR_W=5, NUM_REGS=32, XLEN=32.
  - Source ids WB_SRC_FAST=0, WB_SRC_SLOW=1.
  - STARVE_CNT_W=4.
- One sub-module, cpu_scoreboard: busy vector, set/clear logic, hazard compare, sb_err.
- The arbiter and starve counter stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-run with busy=0x0000_0100 -> busy=0, rf_we3=0, iss_stall=1 immediately; after release iss_stall=0 for rs1=rs2=rd=0.
- Contention: wb0 and wb1 valid together, wb0_rd=3/0xAAAA_0003, wb1_rd=5/0x5555_0005 -> cycle 0 rf_a3=3, rf_we3=1, wb0_ready=1.
- Starvation: keep wb0 and wb1 valid continuously for 6 cycles -> wb1 granted on exactly the 5th cycle (after 4 losses), counter back to 0.
- RAW hazard: issue long op rd=8 -> busy[8]=1 next cycle.
  - Issue rs1=8 -> iss_stall=1.
  - wb1 writes rd=8 -> stall still 1 that cycle, 0 the cycle after.
- x0 handling: wb0 rd=0 data=0xDEAD_BEEF -> wb0_ready=1, rf_we3=0. Issue long rd=0 -> busy stays 0.
- Scoreboard error: wb1 transfer to rd=12 with busy[12]=0 -> sb_err=1 next cycle, stays 1 until reset.
